mult_sequencer: RTL and testbench
=================================

Name: mult_sequencer

Overview:
Control unit for the 4-bit shift-add multiplier CPU. It steps the program counter into the instruction memory and waits out the memory's one-cycle registered read. It then decodes the returned opcode into one-cycle datapath strobes and loops the Add/Shift_Right pair once per multiplier bit. A start/busy/done handshake lets the top level launch a multiply and detect completion.

Parameters:
ITERATIONS, 4, number of Add/Shift_Right passes (multiplier bit width), legal range 1..15
PC_W, 4, program counter width
OP_W, 4, opcode width

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request a multiply; sampled only in IDLE
opcode  input  OP_W  opcode from instruction memory, valid one cycle after pc changes
mult_lsb  input  1  current LSB of the multiplier/product shift register
pc  output  PC_W  instruction address to memory
clr_load  output  1  strobe: clear accumulator, load multiplier
add_load  output  1  strobe: load operand A into datapath
add_en  output  1  strobe: accumulator += B (gated by mult_lsb)
shift_en  output  1  strobe: shift product register right by 1
disp_en  output  1  strobe: latch product to display
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on completion
err  output  1  one-cycle pulse on illegal opcode

Behaviour:
- Reset (async, reset_n=0): state=IDLE, pc=0, iteration count=0, all outputs 0.
- Opcodes: 0 CLEAR_LOAD, 1 ADD_LOAD, 2 ADD, 3 SHIFT_RIGHT, 4 DISP. Values 5..15 are illegal.
- States: IDLE, FETCH, EXEC, DONE.
  - IDLE: pc=0. If start=1, go to FETCH on the next edge.
  - FETCH: pc is stable and memory samples it; no strobes; go to EXEC.
  - EXEC: opcode is valid. Exactly one strobe is asserted combinationally for this single cycle, then next-pc is selected (below).
  - DONE: done=1 for one cycle, then IDLE.
- Each instruction takes 2 cycles (FETCH+EXEC).
- Next-pc rules in EXEC:
  - CLEAR_LOAD: clr_load=1; pc<=1; go to FETCH.
  - ADD_LOAD: add_load=1; pc<=2; go to FETCH.
  - ADD: add_en=mult_lsb. A skipped add still consumes the cycle. pc<=3; go to FETCH.
  - SHIFT_RIGHT: shift_en=1.
    - If count==ITERATIONS-1: count<=0, pc<=4.
    - Otherwise: count<=count+1, pc<=2.
    - Go to FETCH in both cases.
  - DISP: disp_en=1; pc<=0; go to DONE.
  - Illegal opcode: err=1 for this cycle; no datapath strobe; pc<=0; count<=0; go to IDLE; done is not asserted.
- Iteration count is $clog2(ITERATIONS+1) bits wide, unsigned, and never wraps past ITERATIONS-1.
- Latency, start sampled to done pulse: 2*(3+2*ITERATIONS)+1 cycles. With ITERATIONS=4 that is 23 cycles (done in the 23rd cycle after the start edge).
- start is ignored while busy=1. A start held high in IDLE after DONE launches a new run.
- Strobes are mutually exclusive, and at most one is high per cycle.
- Reset mid-operation: immediate return to IDLE. No done or err pulse; the datapath is left as is and is recleared by the next CLEAR_LOAD.
- mult_lsb is sampled only in EXEC with opcode ADD. Its value is don't-care otherwise.

Decomposition:
- Package mult_pkg holds:
  - opcode constants OP_CLEAR_LOAD..OP_DISP;
  - state encoding (IDLE, FETCH, EXEC, DONE);
  - program addresses PC_CLR=0, PC_ADDLD=1, PC_ADD=2, PC_SHR=3, PC_DISP=4.
- One combinational sub-module, mult_op_decode (opcode, exec, mult_lsb -> strobes, illegal), keeps decode separate from the FSM/pc/counter logic.

Test Plan:
1. Reset: hold reset_n=0 mid-clock -> pc=0, busy=0, done=0, all strobes 0 asynchronously; release and idle 5 cycles -> no change.
2. Full run, ITERATIONS=4, mult_lsb=1,0,1,1 at successive ADDs -> pc sequence 0,1,2,3,2,3,2,3,2,3,4; add_en on iterations 0,2,3 only; shift_en 4 times; disp_en once; done in cycle 23; busy low afterwards.
3. start pulsed again at cycle 10 of a run -> ignored; pc sequence and done timing identical to scenario 2.
4. Memory returns opcode 4'b0111 at pc=1 -> err=1 for one cycle, no strobe, busy low the next cycle, pc=0, done never asserted.
5. reset_n asserted during the second SHIFT_RIGHT EXEC -> IDLE immediately; a new start completes a full 23-cycle run with count restarting at 0.
6. ITERATIONS=1 build, start with mult_lsb=1 -> pc 0,1,2,3,4; one add_en, one shift_en; done in cycle 11.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared opcodes, FSM states and program addresses for the multiplier sequencer
package mult_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

    localparam logic [3:0] OP_CLEAR_LOAD  = 4'd0;
    localparam logic [3:0] OP_ADD_LOAD    = 4'd1;
    localparam logic [3:0] OP_ADD         = 4'd2;
    localparam logic [3:0] OP_SHIFT_RIGHT = 4'd3;
    localparam logic [3:0] OP_DISP        = 4'd4;

    localparam logic [3:0] PC_CLR   = 4'd0;
    localparam logic [3:0] PC_ADDLD = 4'd1;
    localparam logic [3:0] PC_ADD   = 4'd2;
    localparam logic [3:0] PC_SHR   = 4'd3;
    localparam logic [3:0] PC_DISP  = 4'd4;

endpackage

// File: rtl/mult_op_decode.sv
// mult_op_decode: turns the fetched opcode into one-cycle datapath strobes while executing
module mult_op_decode
    import mult_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] opcode,
    input  logic            exec,
    input  logic            mult_lsb,
    output logic            clr_load,
    output logic            add_load,
    output logic            add_en,
    output logic            shift_en,
    output logic            disp_en,
    output logic            illegal
);

    assign clr_load = exec && opcode == OP_W'(OP_CLEAR_LOAD);
    assign add_load = exec && opcode == OP_W'(OP_ADD_LOAD);
    assign add_en   = exec && opcode == OP_W'(OP_ADD) && mult_lsb;
    assign shift_en = exec && opcode == OP_W'(OP_SHIFT_RIGHT);
    assign disp_en  = exec && opcode == OP_W'(OP_DISP);
    assign illegal  = exec && opcode > OP_W'(OP_DISP);

endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: fetch/execute control for the shift-add multiplier program
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int ITERATIONS = 4,
    parameter int PC_W       = 4,
    parameter int OP_W       = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            start,
    input  logic [OP_W-1:0] opcode,
    input  logic            mult_lsb,
    output logic [PC_W-1:0] pc,
    output logic            clr_load,
    output logic            add_load,
    output logic            add_en,
    output logic            shift_en,
    output logic            disp_en,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int CW = $clog2(ITERATIONS + 1);

    state_t          state, state_d;
    logic [PC_W-1:0] pc_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            illegal;
    logic            last_iter;

    mult_op_decode #(.OP_W(OP_W)) u_dec (
        .opcode   (opcode),
        .exec     (state == EXEC),
        .mult_lsb (mult_lsb),
        .clr_load (clr_load),
        .add_load (add_load),
        .add_en   (add_en),
        .shift_en (shift_en),
        .disp_en  (disp_en),
        .illegal  (illegal)
    );

    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign err       = illegal;
    assign last_iter = cnt == CW'(ITERATIONS - 1);

    // state, program counter and iteration count registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pc    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            cnt   <= cnt_d;
        end
    end

    // next state and next pc; an illegal opcode aborts straight back to idle
    always_comb begin
        state_d = state;
        pc_d    = pc;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                pc_d    = '0;
                state_d = start ? FETCH : IDLE;
            end
            FETCH: state_d = EXEC;
            EXEC: begin
                state_d = FETCH;
                if (illegal) begin
                    state_d = IDLE;
                    pc_d    = '0;
                    cnt_d   = '0;
                end else if (opcode == OP_W'(OP_CLEAR_LOAD)) begin
                    pc_d = PC_W'(PC_ADDLD);
                end else if (opcode == OP_W'(OP_ADD_LOAD)) begin
                    pc_d = PC_W'(PC_ADD);
                end else if (opcode == OP_W'(OP_ADD)) begin
                    pc_d = PC_W'(PC_SHR);
                end else if (opcode == OP_W'(OP_SHIFT_RIGHT)) begin
                    pc_d  = last_iter ? PC_W'(PC_DISP) : PC_W'(PC_ADD);
                    cnt_d = last_iter ? '0 : cnt + 1'b1;
                end else begin
                    state_d = DONE;
                    pc_d    = PC_W'(PC_CLR);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer: table-driven cycle checks of the sequencer with a registered instruction memory
module tb_mult_sequencer;

    typedef struct packed {
        logic       lsb;
        logic [3:0] pc;
        logic [4:0] strb;
        logic       err;
        logic       busy;
        logic       done;
    } vec_t;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] CLR  = 5'b10000;
    localparam logic [4:0] ALD  = 5'b01000;
    localparam logic [4:0] ADD  = 5'b00100;
    localparam logic [4:0] SHR  = 5'b00010;
    localparam logic [4:0] DSP  = 5'b00001;

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       start = 1'b0;
    logic       mult_lsb = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] prog [16];
    logic [3:0] op1, op2, pc1, pc2;
    logic       cl1, al1, ae1, se1, de1, bu1, dn1, er1;
    logic       cl2, al2, ae2, se2, de2, bu2, dn2, er2;
    logic [11:0] obs;
    vec_t       tbl [$];
    int         n_checks = 0;
    int         n_err = 0;

    always #5 clock = ~clock;

    mult_sequencer #(.ITERATIONS(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .start(start & ~sel), .opcode(op1), .mult_lsb(mult_lsb),
        .pc(pc1), .clr_load(cl1), .add_load(al1), .add_en(ae1), .shift_en(se1), .disp_en(de1),
        .busy(bu1), .done(dn1), .err(er1)
    );

    mult_sequencer #(.ITERATIONS(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start & sel), .opcode(op2), .mult_lsb(mult_lsb),
        .pc(pc2), .clr_load(cl2), .add_load(al2), .add_en(ae2), .shift_en(se2), .disp_en(de2),
        .busy(bu2), .done(dn2), .err(er2)
    );

    always @(posedge clock) begin
        op1 <= prog[pc1];
        op2 <= prog[pc2];
    end

    assign obs = sel ? {pc2, cl2, al2, ae2, se2, de2, er2, bu2, dn2}
                     : {pc1, cl1, al1, ae1, se1, de1, er1, bu1, dn1};

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got pc/strb/err/busy/done=%h expected %h", nm, act, exp);
        end
    endtask

    task automatic row(input logic l, input logic [3:0] p, input logic [4:0] s,
                       input logic e, input logic b, input logic d);
        vec_t v;
        v = '{l, p, s, e, b, d};
        tbl.push_back(v);
    endtask

    // FETCH row drives the opposite lsb to show it is ignored outside an ADD execute
    task automatic instr(input logic [3:0] p, input logic [4:0] s, input logic l);
        row(~l, p, NONE, 1'b0, 1'b1, 1'b0);
        row(l, p, s, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic full4();
        tbl.delete();
        instr(4'd0, CLR, 1'b0);
        instr(4'd1, ALD, 1'b0);
        instr(4'd2, ADD, 1'b1);
        instr(4'd3, SHR, 1'b1);
        instr(4'd2, NONE, 1'b0);
        instr(4'd3, SHR, 1'b0);
        instr(4'd2, ADD, 1'b1);
        instr(4'd3, SHR, 1'b0);
        instr(4'd2, ADD, 1'b1);
        instr(4'd3, SHR, 1'b1);
        instr(4'd4, DSP, 1'b0);
        row(1'b0, 4'd0, NONE, 1'b0, 1'b1, 1'b1);
        row(1'b0, 4'd0, NONE, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run(input string tag, input int restart_at, input int abort_at);
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int k = 0; k < tbl.size(); k++) begin
            mult_lsb = tbl[k].lsb;
            start = (k + 1 == restart_at);
            @(negedge clock);
            chk($sformatf("%s c%0d", tag, k + 1), obs,
                {tbl[k].pc, tbl[k].strb, tbl[k].err, tbl[k].busy, tbl[k].done});
            if (k + 1 == abort_at) begin
                reset_n = 1'b0;
                #1 chk($sformatf("%s async reset", tag), obs, 12'h000);
                #2 reset_n = 1'b1;
                start = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) prog[i] = 4'hF;
        for (int i = 0; i < 5; i++) prog[i] = 4'(i);

        #2 reset_n = 1'b0;
        #1 chk("reset dut4", obs, 12'h000);
        sel = 1'b1;
        #0 chk("reset dut1", obs, 12'h000);
        sel = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("idle %0d", i), obs, 12'h000);
        end

        full4();
        run("full", 0, 0);
        run("restart", 10, 0);

        prog[1] = 4'b0111;
        tbl.delete();
        instr(4'd0, CLR, 1'b0);
        row(1'b1, 4'd1, NONE, 1'b0, 1'b1, 1'b0);
        row(1'b0, 4'd1, NONE, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) row(1'b0, 4'd0, NONE, 1'b0, 1'b0, 1'b0);
        run("illegal", 0, 0);
        prog[1] = 4'd1;

        full4();
        run("abort", 0, 12);
        run("rerun", 0, 0);

        sel = 1'b1;
        tbl.delete();
        instr(4'd0, CLR, 1'b0);
        instr(4'd1, ALD, 1'b0);
        instr(4'd2, ADD, 1'b1);
        instr(4'd3, SHR, 1'b1);
        instr(4'd4, DSP, 1'b0);
        row(1'b0, 4'd0, NONE, 1'b0, 1'b1, 1'b1);
        row(1'b0, 4'd0, NONE, 1'b0, 1'b0, 1'b0);
        run("iter1", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
